// File: rtl/int4_vec_packer_if.sv
// Operand-side bus of the INT4 vector packer: 32-bit beat input, 264-bit vector output.
interface int4_vec_packer_if #(
  parameter int ELEM_BITS  = 4,
  parameter int NUM_ELEM   = 64,
  parameter int BEAT_ELEMS = 8,
  parameter int SCALE_BITS = 8
);
  localparam int BEAT_BITS = ELEM_BITS * BEAT_ELEMS;
  localparam int VEC_BITS  = SCALE_BITS + NUM_ELEM * ELEM_BITS;

  logic                  in_valid;
  logic                  in_ready;
  logic [BEAT_BITS-1:0]  in_data;
  logic [SCALE_BITS-1:0] in_scale;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [VEC_BITS-1:0]   out_vec;
  logic                  int4_en;
  logic [15:0]           vec_count;

  modport master (
    output in_valid, in_data, in_scale, in_last, out_ready,
    input  in_ready, out_valid, out_vec, int4_en, vec_count
  );

  modport slave (
    input  in_valid, in_data, in_scale, in_last, out_ready,
    output in_ready, out_valid, out_vec, int4_en, vec_count
  );
endinterface

// File: rtl/int4_vec_packer.sv
// Packs a stream of 8-element int4 beats plus a scale code into one MAC operand vector,
// with an assembly register and an output register so beats can stream at full rate.
module int4_vec_packer #(
  parameter int ELEM_BITS  = 4,
  parameter int NUM_ELEM   = 64,
  parameter int BEAT_ELEMS = 8,
  parameter int SCALE_BITS = 8
) (
  input logic              clk,
  input logic              rst_n,
  int4_vec_packer_if.slave bus
);
  localparam int BEAT_BITS = ELEM_BITS * BEAT_ELEMS;
  localparam int VEC_BITS  = SCALE_BITS + NUM_ELEM * ELEM_BITS;
  localparam int NUM_BEATS = NUM_ELEM / BEAT_ELEMS;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  logic [CNT_W-1:0]    beat_cnt;
  logic                asm_full;
  logic [VEC_BITS-1:0] asm_q;
  logic [VEC_BITS-1:0] asm_next;
  logic [VEC_BITS-1:0] out_vec_q;
  logic                out_valid_q;
  logic [15:0]         vec_count_q;
  logic                in_hs;
  logic                out_hs;
  logic                vec_done;
  logic                out_free;

  assign in_hs    = bus.in_valid && !asm_full;
  assign out_hs   = out_valid_q && bus.out_ready;
  assign out_free = !out_valid_q || bus.out_ready;
  assign vec_done = in_hs && (bus.in_last || (beat_cnt == CNT_W'(NUM_BEATS - 1)));

  // The first beat clears all element bits so a short vector is zero-filled.
  always_comb begin
    asm_next = asm_q;
    if (beat_cnt == '0) begin
      asm_next = '0;
      asm_next[SCALE_BITS-1:0] = bus.in_scale;
    end
    asm_next[SCALE_BITS + int'(beat_cnt) * BEAT_BITS +: BEAT_BITS] = bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt    <= '0;
      asm_full    <= 1'b0;
      asm_q       <= '0;
      out_vec_q   <= '0;
      out_valid_q <= 1'b0;
      vec_count_q <= '0;
    end else begin
      if (in_hs) begin
        asm_q    <= asm_next;
        beat_cnt <= vec_done ? '0 : beat_cnt + CNT_W'(1);
      end

      // A completing vector bypasses the assembly register whenever the output slot frees up.
      if (vec_done && out_free) begin
        out_vec_q   <= asm_next;
        out_valid_q <= 1'b1;
      end else if (vec_done) begin
        asm_full <= 1'b1;
      end else if (asm_full && out_hs) begin
        out_vec_q <= asm_q;
        asm_full  <= 1'b0;
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end

      if (out_hs) begin
        vec_count_q <= vec_count_q + 16'd1;
      end
    end
  end

  assign bus.in_ready  = !asm_full;
  assign bus.out_valid = out_valid_q;
  assign bus.int4_en   = out_valid_q;
  assign bus.out_vec   = out_vec_q;
  assign bus.vec_count = vec_count_q;
endmodule

// File: doc/int4_vec_packer.md
Name: int4_vec_packer

Overview:
- Producer side of the INT4 MAC operand interface: assembles a stream of 32-bit beats, each holding 8 signed int4 elements, into one 264-bit operand vector.
- Vector layout: bits [7:0] carry an 8-bit per-vector scale code; bits [263:8] carry 64 int4 elements.
- One instance feeds each MAC operand port (a_vec or b_vec) and drives the MAC enable from its output valid.
- Valid/ready on both sides; a two-deep buffer (assembly register plus output register) sustains one beat per cycle.

Parameters:
- ELEM_BITS, 4, bits per element (only 4 supported)
- NUM_ELEM, 64, elements per vector
- BEAT_ELEMS, 8, elements per input beat; NUM_ELEM must be a multiple of BEAT_ELEMS
- SCALE_BITS, 8, width of the scale/header field at the vector LSBs

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  32  8 int4 elements; element i at [4i+3:4i]
- in_scale  in  8  scale code, sampled on the first beat of a vector only
- in_last  in  1  final beat of a vector; remaining elements are zero-filled
- out_valid  out  1  out_vec holds a complete vector
- out_ready  in  1  consumer accepts the vector
- out_vec  out  264  {elements 63..0, scale}
- int4_en  out  1  equals out_valid; drives the MAC enable
- vec_count  out  16  vectors emitted (out handshakes), wraps 0xFFFF->0

Behaviour:
- Reset (async, rst_n=0): out_valid=0, int4_en=0, out_vec=0, vec_count=0, in_ready=1, beat_cnt=0, asm_full=0, assembly register=0.
- Reset mid-vector discards all partial and buffered data; no output is produced for it.
- Beat acceptance: on each edge with in_valid && in_ready, beat k = beat_cnt writes element k*8+i to assembly bits [8+4(k*8+i) +: 4].
- On beat 0, in_scale is written to bits [7:0] and all higher element bits are cleared (zero-fill base).
- Completion: a vector completes when beat_cnt == NUM_ELEM/BEAT_ELEMS-1 (7), or when in_last=1 on any beat.
- On completion beat_cnt returns to 0. Elements after the last beat are 0; in_last on beat 0 gives a vector of 8 elements plus scale.
- in_last on beat 7 is identical to a normal completion.
- Transfer on completion edge:
  - If (!out_valid || out_ready), the output register loads the completed vector (including the current beat) at that same edge, and out_valid=1 the next cycle. Latency from last-beat handshake to out_valid is 1 cycle.
  - Otherwise asm_full is set to 1 and in_ready goes to 0 from the next cycle.
- Drain: when asm_full=1 and out_valid && out_ready, the output register loads the assembly register, asm_full clears, and in_ready returns to 1 the next cycle.
- in_ready is !asm_full, derived from registers only; there is no combinational path from out_ready to in_ready.
- Output handshake: out_valid && out_ready with nothing new to load clears out_valid. vec_count increments on every output handshake.
- out_vec is stable while out_valid && !out_ready.
- Back-to-back: with out_ready held 1, 8 beats per vector stream with no bubbles, at one vector per 8 cycles.
- Simultaneous completion and output handshake on the same edge: the new vector replaces the old one in the output register, out_valid stays 1, and asm_full is not set.
- in_scale and in_last are ignored when no handshake occurs. in_scale on beats 1..7 is ignored.

Test Plan:
- Reset, then 8 beats in_data=32'h76543210, in_scale=8'hA5, out_ready=1 -> one cycle after beat 8: out_valid=1, out_vec[7:0]=8'hA5, every 32-bit group = 32'h76543210; vec_count=1 after the handshake.
- 3 beats of 32'hFFFFFFFF (all -1) with in_last on beat 3 -> out_vec[103:8] all ones, out_vec[263:104]=0.
- out_ready=0, stream 16 beats -> first vector held stable; in_ready drops after beat 16 and stays 0. Raise out_ready -> vector 1 then vector 2 delivered in order, in_ready returns to 1 one cycle after the drain.
- Continuous input with out_ready=1 for 4 vectors -> in_ready never drops; out_valid pulses one cycle every 8 cycles; vec_count=4.
- Assert rst_n=0 after beat 5 of a vector -> all outputs zero asynchronously; 8 fresh beats afterwards produce a vector containing no stale data.
- Preload vec_count to 0xFFFF via 65535 handshakes (or force) plus one more -> vec_count=0.
